// File: rtl/stream_pkg.sv
// Shared constants for the stream reader: parameter defaults and FSM encoding.
package stream_pkg;

   localparam int DEF_BEAT_BYTES = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous beat FIFO with occupancy count; head reads as zero when empty.
module stream_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     areset,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;

   // Storage write; contents need no reset because the head is masked when empty.
   always_ff @(posedge clock) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clock or negedge areset) begin
      if (!areset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
      end
   end

   assign count_o = wr_q - rd_q;
   assign dout_o  = (count_o != '0) ? mem_q[rd_q[AW-1:0]] : '0;

endmodule

// File: rtl/stream_reader.sv
// Turns a (length, address) read command into beat-aligned memory reads and
// streams the returned beats out in order, issuing only when FIFO space is reserved.
module stream_reader
   import stream_pkg::*;
#(
   parameter int BEAT_BYTES = DEF_BEAT_BYTES,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                    clock,
   input  logic                    areset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [33:0]             req_len,
   input  logic [63:0]             req_addr_address,
   output logic                    inProgress,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic [8*BEAT_BYTES-1:0] data,
   output logic                    mem_ar_valid,
   input  logic                    mem_ar_ready,
   output logic [63:0]             mem_ar_addr,
   input  logic                    mem_r_valid,
   input  logic [8*BEAT_BYTES-1:0] mem_r_data,
   output logic                    err_unexpected
);

   localparam int OFS = $clog2(BEAT_BYTES);
   localparam int BW  = 35 - OFS;              // wide enough for ceil(2^34-1 / BEAT_BYTES)
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q, state_d;
   logic [63:0]   addr_q, addr_d;
   logic [BW-1:0] issue_q, issue_d;
   logic [BW-1:0] drain_q, drain_d;
   logic [CW-1:0] outst_q, outst_d;
   logic          err_q, err_d;

   logic [34:0]   len_rnd;
   logic [BW-1:0] beats_w;
   logic [CW-1:0] fifo_cnt;
   logic          ar_fire, d_fire, push, credit;

   assign len_rnd = {1'b0, req_len} + 35'(BEAT_BYTES - 1);
   assign beats_w = BW'(len_rnd >> OFS);

   // Outstanding responses already own a FIFO slot, so count them against depth.
   assign credit  = ({1'b0, fifo_cnt} + {1'b0, outst_q}) < (CW+1)'(FIFO_DEPTH);

   assign req_ready      = (state_q == ST_IDLE);
   assign inProgress     = (state_q != ST_IDLE);
   assign mem_ar_valid   = (state_q == ST_ISSUE) && credit;
   assign mem_ar_addr    = addr_q;
   assign ar_fire        = mem_ar_valid && mem_ar_ready;
   assign d_fire         = data_valid && data_ready;
   assign push           = mem_r_valid && (outst_q != '0);
   assign data_valid     = (fifo_cnt != '0);
   assign err_unexpected = err_q;

   stream_fifo #(.W(8*BEAT_BYTES), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .areset  (areset),
      .push_i  (push),
      .din_i   (mem_r_data),
      .pop_i   (d_fire),
      .dout_o  (data),
      .count_o (fifo_cnt)
   );

   // Command FSM: latch the aligned command, walk addresses, then drain remaining beats.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      issue_d = issue_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && beats_w != '0) begin
               state_d = ST_ISSUE;
               addr_d  = req_addr_address & ~64'(BEAT_BYTES - 1);
               issue_d = beats_w;
               drain_d = beats_w;
            end
         end
         ST_ISSUE: begin
            if (ar_fire) begin
               addr_d  = addr_q + 64'(BEAT_BYTES);
               issue_d = issue_q - BW'(1);
               if (issue_q == BW'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (d_fire && drain_q == BW'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && d_fire) drain_d = drain_q - BW'(1);
   end

   // Issue and response in the same cycle cancel; stray responses are dropped and flagged.
   always_comb begin
      outst_d = outst_q + CW'(ar_fire) - CW'(push);
      err_d   = err_q | (mem_r_valid && outst_q == '0);
   end

   // State registers, cleared immediately by reset so any command in flight is abandoned.
   always_ff @(posedge clock or negedge areset) begin
      if (!areset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         issue_q <= '0;
         drain_q <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         issue_q <= issue_d;
         drain_q <= drain_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/stream_reader.md
STREAM_READER -- requirements
Module: stream_reader

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 8, meaning bytes per data beat (power of two; beat width = 8*BEAT_BYTES).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning beat-buffer entries (power of two, >=2).
REQ-003 SHALL have port clock  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port areset  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have ports req_valid in 1, req_ready out 1  read-command handshake.
REQ-006 SHALL have ports req_len in 34 (bytes) and req_addr_address in 64 (byte address)  command payload.
REQ-007 SHALL have port inProgress  out  1  high while a command is being served.
REQ-008 SHALL have ports data_valid out 1, data_ready in 1, data out 8*BEAT_BYTES  outgoing beat stream.
REQ-009 SHALL have ports mem_ar_valid out 1, mem_ar_ready in 1, mem_ar_addr out 64  memory read-address channel.
REQ-010 SHALL have ports mem_r_valid in 1, mem_r_data in 8*BEAT_BYTES  in-order memory response, no backpressure.
REQ-011 SHALL have port err_unexpected  out  1  sticky: response arrived with nothing outstanding.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-013 SHALL drive req_ready = (state==IDLE); command accepted on req_valid&&req_ready.
REQ-014 SHALL compute beats = ceil(req_len/BEAT_BYTES) at acceptance; address latched with low log2(BEAT_BYTES) bits cleared.
REQ-015 SHALL, for beats==0, remain in IDLE; inProgress stays 0; no mem_ar issued.
REQ-016 SHALL, for beats>0, go IDLE->ISSUE; inProgress=1 from the next cycle.
REQ-017 SHALL in ISSUE assert mem_ar_valid only while (fifo_count + outstanding) < FIFO_DEPTH (credit rule).
REQ-018 SHALL on mem_ar fire increment outstanding, advance address by BEAT_BYTES, decrement beats_to_issue.
REQ-019 SHALL hold mem_ar_addr stable while mem_ar_valid && !mem_ar_ready.
REQ-020 SHALL go ISSUE->DRAIN on the fire of the last address.
REQ-021 SHALL on mem_r_valid with outstanding>0 push mem_r_data into the FIFO and decrement outstanding; same-cycle issue and response net to zero change.
REQ-022 SHALL on mem_r_valid with outstanding==0 drop the data and set err_unexpected until reset.
REQ-023 SHALL drive data_valid = FIFO non-empty; data = FIFO head; pop on data_valid&&data_ready; FIFO push and pop allowed in the same cycle, including when full and when empty (bypass not required; empty-push appears next cycle).
REQ-024 SHALL go DRAIN->IDLE on the data fire of the final beat; inProgress=0 in the following cycle, req_ready=1 in the following cycle.
REQ-025 SHALL preserve beat order: output order equals address order.
REQ-026 SHALL never overflow the FIFO; credit rule guarantees space for every outstanding response.
REQ-027 SHALL hold data stable while data_valid && !data_ready.

Reset
REQ-028 SHALL on areset==0 immediately force state=IDLE, outstanding=0, FIFO empty, err_unexpected=0.
REQ-029 SHALL drive during and after reset: req_ready=1 (after release), inProgress=0, data_valid=0, mem_ar_valid=0, mem_ar_addr=0, data=0.
REQ-030 SHALL abandon any command on mid-operation reset; the memory side is reset by the same signal.

Structure
REQ-031 SHALL place the state enum and BEAT_BYTES/FIFO_DEPTH defaults in shared package stream_pkg.
REQ-032 SHALL instantiate one sub-module, stream_fifo (synchronous FIFO with count output).

Verification
REQ-033 SHALL test: len=32, addr=0x1000, always-ready -> mem_ar addrs 0x1000,0x1008,0x1010,0x1018; 4 beats out in order; inProgress low after last beat.
REQ-034 SHALL test: len=64, data_ready=0 -> exactly 4 addrs issued then mem_ar_valid=0; release data_ready -> remaining 4 issued, 8 beats out.
REQ-035 SHALL test: len=0 -> no mem_ar, inProgress never 1, req_ready stays 1.
REQ-036 SHALL test: len=12, addr=0x1003 -> 2 beats, addrs 0x1000,0x1008.
REQ-037 SHALL test: mem_r_valid in IDLE -> err_unexpected=1, no data_valid; areset low -> err_unexpected=0.
REQ-038 SHALL test: areset asserted mid-ISSUE of len=64 -> outputs reset immediately; new len=8 command completes with 1 beat.
